// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output capture block: default sizes,
// frame length derivation and the capture FSM state encoding.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 16;
  localparam int N_INPUTS       = 64;
  localparam int N_TAPS         = 16;
  // Full linear convolution yields inputs + taps - 1 results per frame
  localparam int DEF_FRAME_LEN  = N_INPUTS + N_TAPS - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is always presented on rd_data
// and the extra pointer MSB distinguishes full from empty.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]         wr_ptr;
  logic [LW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] last_head;
  logic                  do_pop;
  logic                  do_push;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a write when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  // Once drained, keep showing the last head rather than a stale memory slot
  assign rd_data = empty ? last_head : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop) begin
        rd_ptr    <= rd_ptr + LW'(1);
        last_head <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/conv_output_capture.sv
// Output sink for the convolution stream: frames results, buffers them in a
// FWFT FIFO for a valid/ready reader, flags overflow and pulses frame_done.
module conv_output_capture
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  localparam int LVL_W     = $clog2(DEPTH) + 1,
  localparam int CNT_W     = $clog2(FRAME_LEN) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] y_in,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic        [DATA_WIDTH-1:0] rd_data,
  output logic        [LVL_W-1:0]      level,
  output logic        [CNT_W-1:0]      sample_cnt,
  output logic                         overflow,
  output logic                         frame_done
);

  cap_state_t       state;
  cap_state_t       state_nxt;
  logic             accept;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_sample;

  assign accept      = valid_in && ((state == IDLE) || (state == CAPTURE));
  assign rd_valid    = !empty;
  assign pop         = rd_valid && rd_ready;
  assign push        = accept && (!full || pop);
  assign drop        = accept && full && !pop;
  // A new frame restarts counting from the sample that opens it
  assign cnt_inc     = ((state == IDLE) ? '0 : sample_cnt) + CNT_W'(1);
  assign last_sample = accept && (cnt_inc == CNT_W'(FRAME_LEN));
  assign frame_done  = (state == DONE);

  sync_fifo_fwft #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_data(y_in),
    .pop    (pop),
    .rd_data(rd_data),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_sample ? DRAIN : CAPTURE;
      CAPTURE: if (last_sample) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dropped samples are still counted so framing stays aligned with the core
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) sample_cnt <= cnt_inc;
      if (accept && (state == IDLE)) overflow <= drop;
      else if (drop)                 overflow <= 1'b1;
    end
  end

endmodule
